// File: rtl/scene_spi_master.sv
// SPI initiator that uploads a scene snapshot (background plus N_POLY triangles)
// as one CS-framed transaction per register group, then pulses en_load.
module scene_spi_master #(
    parameter int WCOLOR   = 6,
    parameter int WPX      = 7,
    parameter int WPY      = 6,
    parameter int N_POLY   = 6,
    parameter int SCK_HALF = 2,
    parameter int CS_GAP   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [WCOLOR-1:0]        bg_color_in,
    input  logic [WCOLOR*N_POLY-1:0] poly_color_in,
    input  logic [WPX*N_POLY-1:0]    v0_x_in,
    input  logic [WPX*N_POLY-1:0]    v1_x_in,
    input  logic [WPX*N_POLY-1:0]    v2_x_in,
    input  logic [WPY*N_POLY-1:0]    v0_y_in,
    input  logic [WPY*N_POLY-1:0]    v1_y_in,
    input  logic [WPY*N_POLY-1:0]    v2_y_in,
    input  logic [N_POLY-1:0]        poly_enable_in,
    output logic                     cs_out,
    output logic                     sck_out,
    output logic                     mosi_out,
    output logic                     en_load_out,
    output logic                     busy,
    output logic                     done
);
    localparam int PW   = 1 + WCOLOR + 3 * (WPX + WPY);
    localparam int FL   = 8 + PW;
    localparam int BL   = 8 + WCOLOR;
    localparam int FW   = $clog2(N_POLY + 1);
    localparam int CMAX = (SCK_HALF > CS_GAP) ? SCK_HALF : CS_GAP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BW   = $clog2(FL + 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(SCK_HALF - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(N_POLY);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4,
        LOAD  = 3'd5
    } state_t;

    state_t state_r, state_nx;
    logic [CW-1:0] cnt_r, cnt_nx;
    logic [BW-1:0] bit_r, bit_nx;
    logic [FW-1:0] frame_r, frame_nx;
    logic phase_r, phase_nx;
    logic [FL-1:0] shreg_r, shreg_nx;
    logic capture_s, load_s, shift_s;
    logic [PW-1:0] poly_word_s;
    int pidx_s;
    logic cs_nx, sck_nx, mosi_nx, busy_nx, done_nx;

    logic [WCOLOR-1:0]        sh_bg_r;
    logic [WCOLOR*N_POLY-1:0] sh_color_r;
    logic [WPX*N_POLY-1:0]    sh_v0x_r, sh_v1x_r, sh_v2x_r;
    logic [WPY*N_POLY-1:0]    sh_v0y_r, sh_v1y_r, sh_v2y_r;
    logic [N_POLY-1:0]        sh_en_r;

    // Next-state and counter sequencing; SHIFT alternates high/low SCK phases.
    always_comb begin
        state_nx  = state_r;
        cnt_nx    = cnt_r;
        bit_nx    = bit_r;
        frame_nx  = frame_r;
        phase_nx  = phase_r;
        capture_s = 1'b0;
        load_s    = 1'b0;
        shift_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx  = SETUP;
                    capture_s = 1'b1;
                    load_s    = 1'b1;
                    frame_nx  = {FW{1'b0}};
                    cnt_nx    = {CW{1'b0}};
                    phase_nx  = 1'b0;
                end else begin
                    cnt_nx = {CW{1'b0}};
                end
            end
            SETUP: begin
                if (cnt_r == HALF_LAST) begin
                    state_nx = SHIFT;
                    cnt_nx   = {CW{1'b0}};
                    phase_nx = 1'b1;
                end else begin
                    cnt_nx = cnt_r + CW'(1);
                end
            end
            SHIFT: begin
                if (cnt_r != HALF_LAST) begin
                    cnt_nx = cnt_r + CW'(1);
                end else if (phase_r) begin
                    cnt_nx   = {CW{1'b0}};
                    shift_s  = 1'b1;
                    phase_nx = 1'b0;
                    if (bit_r == {BW{1'b0}}) begin
                        state_nx = HOLD;
                    end else begin
                        bit_nx = bit_r - BW'(1);
                    end
                end else begin
                    cnt_nx   = {CW{1'b0}};
                    phase_nx = 1'b1;
                end
            end
            HOLD: begin
                if (cnt_r == HALF_LAST) begin
                    state_nx = GAP;
                    cnt_nx   = {CW{1'b0}};
                end else begin
                    cnt_nx = cnt_r + CW'(1);
                end
            end
            GAP: begin
                if (cnt_r != GAP_LAST) begin
                    cnt_nx = cnt_r + CW'(1);
                end else if (frame_r == FRAME_LAST) begin
                    state_nx = LOAD;
                    cnt_nx   = {CW{1'b0}};
                end else begin
                    state_nx = SETUP;
                    cnt_nx   = {CW{1'b0}};
                    frame_nx = frame_r + FW'(1);
                    load_s   = 1'b1;
                end
            end
            LOAD: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (load_s) begin
            bit_nx = (frame_nx == {FW{1'b0}}) ? BW'(BL - 1) : BW'(FL - 1);
        end else begin
            bit_nx = bit_nx;
        end
    end

    // Frame word assembly; frame 0 is built from the live input since the shadow loads in parallel.
    always_comb begin
        pidx_s = (frame_nx == {FW{1'b0}}) ? 0 : int'(frame_nx) - 1;
        poly_word_s = {sh_en_r[pidx_s],
                       sh_color_r[pidx_s*WCOLOR +: WCOLOR],
                       sh_v0x_r[pidx_s*WPX +: WPX], sh_v0y_r[pidx_s*WPY +: WPY],
                       sh_v1x_r[pidx_s*WPX +: WPX], sh_v1y_r[pidx_s*WPY +: WPY],
                       sh_v2x_r[pidx_s*WPX +: WPX], sh_v2y_r[pidx_s*WPY +: WPY]};
        if (load_s && frame_nx == {FW{1'b0}}) begin
            shreg_nx = {8'h00, bg_color_in, {(PW - WCOLOR){1'b0}}};
        end else if (load_s) begin
            shreg_nx = {8'(frame_nx), poly_word_s};
        end else if (shift_s) begin
            shreg_nx = {shreg_r[FL-2:0], 1'b0};
        end else begin
            shreg_nx = shreg_r;
        end
    end

    // Output values for the coming cycle, derived from the next state.
    always_comb begin
        cs_nx   = !(state_nx == SETUP || state_nx == SHIFT || state_nx == HOLD);
        sck_nx  = (state_nx == SHIFT) && phase_nx;
        mosi_nx = cs_nx ? 1'b0 : shreg_nx[FL-1];
        busy_nx = (state_nx != IDLE);
        done_nx = (state_nx == LOAD);
    end

    // Control state, counters and registered SPI outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            bit_r       <= {BW{1'b0}};
            frame_r     <= {FW{1'b0}};
            phase_r     <= 1'b0;
            shreg_r     <= {FL{1'b0}};
            cs_out      <= 1'b1;
            sck_out     <= 1'b0;
            mosi_out    <= 1'b0;
            en_load_out <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_r     <= state_nx;
            cnt_r       <= cnt_nx;
            bit_r       <= bit_nx;
            frame_r     <= frame_nx;
            phase_r     <= phase_nx;
            shreg_r     <= shreg_nx;
            cs_out      <= cs_nx;
            sck_out     <= sck_nx;
            mosi_out    <= mosi_nx;
            en_load_out <= done_nx;
            busy        <= busy_nx;
            done        <= done_nx;
        end
    end

    // Scene snapshot taken on start acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_bg_r    <= {WCOLOR{1'b0}};
            sh_color_r <= {(WCOLOR*N_POLY){1'b0}};
            sh_v0x_r   <= {(WPX*N_POLY){1'b0}};
            sh_v1x_r   <= {(WPX*N_POLY){1'b0}};
            sh_v2x_r   <= {(WPX*N_POLY){1'b0}};
            sh_v0y_r   <= {(WPY*N_POLY){1'b0}};
            sh_v1y_r   <= {(WPY*N_POLY){1'b0}};
            sh_v2y_r   <= {(WPY*N_POLY){1'b0}};
            sh_en_r    <= {N_POLY{1'b0}};
        end else if (capture_s) begin
            sh_bg_r    <= bg_color_in;
            sh_color_r <= poly_color_in;
            sh_v0x_r   <= v0_x_in;
            sh_v1x_r   <= v1_x_in;
            sh_v2x_r   <= v2_x_in;
            sh_v0y_r   <= v0_y_in;
            sh_v1y_r   <= v1_y_in;
            sh_v2y_r   <= v2_y_in;
            sh_en_r    <= poly_enable_in;
        end else begin
            sh_bg_r <= sh_bg_r;
        end
    end
endmodule
